// File: rtl/axi_fft_master.sv
// AXI initiator for the FFT bridge: one INCR write burst from a sample stream, then one INCR read burst to a result stream.
// Optional AXI_MASTER_TIMEOUT_EN adds a per-channel handshake watchdog that aborts the command back to IDLE.
module axi_fft_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_W_WIDTH     = 2,
  parameter int ID_R_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_START,
  input  logic [11:0]           i_BASE_ADDR,
  input  logic [7:0]            i_LEN,
  input  logic [ID_W_WIDTH-1:0] i_W_ID,
  input  logic [ID_R_WIDTH-1:0] i_R_ID,
  input  logic [15:0]           i_S_DATA,
  input  logic                  i_S_VALID,
  output logic                  o_S_READY,
  output logic [DATA_WIDTH-1:0] o_M_DATA,
  output logic                  o_M_VALID,
  input  logic                  i_M_READY,
  input  logic                  i_CALC_END,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_ERROR,
  output logic [2:0]            o_DBG_STATE,
  output logic [11:0]           o_AWADDR,
  output logic [7:0]            o_AWLEN,
  output logic [2:0]            o_AWSIZE,
  output logic [1:0]            o_AWBURST,
  output logic [ID_W_WIDTH-1:0] o_AWID,
  output logic                  o_AWVALID,
  input  logic                  i_AWREADY,
  output logic [15:0]           o_WDATA,
  output logic [1:0]            o_WSTRB,
  output logic                  o_WVALID,
  output logic                  o_WLAST,
  input  logic                  i_WREADY,
  input  logic                  i_BVALID,
  input  logic [ID_W_WIDTH-1:0] i_BID,
  output logic                  o_BREADY,
  output logic [11:0]           o_ARADDR,
  output logic [7:0]            o_ARLEN,
  output logic [2:0]            o_ARSIZE,
  output logic [1:0]            o_ARBURST,
  output logic [ID_R_WIDTH-1:0] o_ARID,
  output logic                  o_ARVALID,
  input  logic                  i_ARREADY,
  input  logic [DATA_WIDTH-1:0] i_RDATA,
  input  logic [ID_R_WIDTH-1:0] i_RID,
  input  logic                  i_RVALID,
  input  logic                  i_RLAST,
  output logic                  o_RREADY
);

  if (DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axi_fft_master: DATA_WIDTH must be 16, 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("axi_fft_master: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_AW        = 3'd1,
    S_W         = 3'd2,
    S_B         = 3'd3,
    S_WAIT_CALC = 3'd4,
    S_AR        = 3'd5,
    S_R         = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  // Handshakes: a beat transfers on a rising clock edge where VALID and READY
  // are both high; VALID never waits on READY and payload holds until transfer.
  state_e                state_q, state_d;
  logic [11:0]           base_q, base_d;
  logic [7:0]            len_q, len_d;
  logic [ID_W_WIDTH-1:0] wid_q, wid_d;
  logic [ID_R_WIDTH-1:0] rid_q, rid_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  tmo;
  logic                  aw_act, w_act, b_act, ar_act, r_act;
  logic                  w_hs, r_hs;

  assign aw_act = (state_q == S_AW) && !tmo;
  assign w_act  = (state_q == S_W);
  assign b_act  = (state_q == S_B) && !tmo;
  assign ar_act = (state_q == S_AR) && !tmo;
  assign r_act  = (state_q == S_R) && !tmo;
  assign w_hs   = w_act && i_S_VALID && i_WREADY;
  assign r_hs   = r_act && i_RVALID && i_M_READY;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    wid_d   = wid_q;
    rid_d   = rid_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_START) begin
          base_d  = i_BASE_ADDR & 12'hFFE;
          len_d   = i_LEN;
          wid_d   = i_W_ID;
          rid_d   = i_R_ID;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = S_AW;
        end
      end
      S_AW: if (i_AWREADY) state_d = S_W;
      S_W: begin
        if (w_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = S_B;
        end
      end
      S_B: begin
        if (i_BVALID) begin
          if (i_BID != wid_q) err_d = 1'b1;
          state_d = S_WAIT_CALC;
        end
      end
      S_WAIT_CALC: if (i_CALC_END) state_d = S_AR;
      S_AR: begin
        if (i_ARREADY) begin
          cnt_d   = 8'd0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (r_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (i_RID != rid_q) err_d = 1'b1;
          // A short or long read burst is flagged, but only RLAST ends it.
          if (i_RLAST) begin
            if (cnt_q != len_q) err_d = 1'b1;
            state_d = S_DONE;
          end else if (cnt_q == len_q) begin
            err_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        chan_wait, chan_hs;

  always_comb begin
    chan_wait = 1'b0;
    chan_hs   = 1'b0;
    case (state_q)
      S_AW: begin chan_wait = 1'b1; chan_hs = i_AWREADY; end
      S_B:  begin chan_wait = 1'b1; chan_hs = i_BVALID; end
      S_AR: begin chan_wait = 1'b1; chan_hs = i_ARREADY; end
      S_R:  begin chan_wait = 1'b1; chan_hs = i_RVALID && i_M_READY; end
      default: ;
    endcase
  end

  assign tmo  = chan_wait && (wd_q == 16'(TIMEOUT_CYCLES));
  assign wd_d = (chan_wait && !chan_hs && (state_d == state_q)) ? wd_q + 16'd1 : 16'd0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) wd_q <= 16'd0;
    else         wd_q <= wd_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      wid_q   <= '0;
      rid_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      wid_q   <= wid_d;
      rid_q   <= rid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Channel controls decode from the state register; stream data paths are pass-through.
  assign o_AWVALID = aw_act;
  assign o_AWADDR  = base_q;
  assign o_AWLEN   = len_q;
  assign o_AWSIZE  = aw_act ? 3'b001 : 3'b000;
  assign o_AWBURST = aw_act ? 2'b01 : 2'b00;
  assign o_AWID    = wid_q;

  assign o_WVALID  = w_act && i_S_VALID;
  assign o_WDATA   = w_act ? i_S_DATA : 16'd0;
  assign o_WSTRB   = w_act ? 2'b11 : 2'b00;
  assign o_WLAST   = w_act && (cnt_q == len_q);
  assign o_S_READY = w_act && i_WREADY;

  assign o_BREADY  = b_act;

  assign o_ARVALID = ar_act;
  assign o_ARADDR  = base_q;
  assign o_ARLEN   = len_q;
  assign o_ARSIZE  = ar_act ? AR_SIZE : 3'b000;
  assign o_ARBURST = ar_act ? 2'b01 : 2'b00;
  assign o_ARID    = rid_q;

  assign o_RREADY  = r_act && i_M_READY;
  assign o_M_VALID = r_act && i_RVALID;
  assign o_M_DATA  = r_act ? i_RDATA : '0;

  assign o_BUSY      = (state_q != S_IDLE);
  assign o_DONE      = (state_q == S_DONE);
  assign o_ERROR     = err_q;
  assign o_DBG_STATE = state_q;

endmodule

// File: tb/tb_axi_fft_master.sv
// Bench for axi_fft_master: directed commands against a scripted AXI slave, W and result beats scoreboarded.
module tb_axi_fft_master;
  localparam int DW = 32;
`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          start, s_valid, m_ready, calc_end;
  logic [11:0]   base_addr;
  logic [7:0]    len_in;
  logic [1:0]    w_id, r_id, bid_in, rid_in;
  logic [15:0]   s_data;
  logic          awready, wready, bvalid, arready, rvalid, rlast;
  logic [DW-1:0] rdata;

  logic          o_S_READY, o_M_VALID, o_BUSY, o_DONE, o_ERROR;
  logic [DW-1:0] o_M_DATA;
  logic [2:0]    o_DBG_STATE;
  logic [11:0]   o_AWADDR, o_ARADDR;
  logic [7:0]    o_AWLEN, o_ARLEN;
  logic [2:0]    o_AWSIZE, o_ARSIZE;
  logic [1:0]    o_AWBURST, o_ARBURST, o_AWID, o_ARID, o_WSTRB;
  logic          o_AWVALID, o_WVALID, o_WLAST, o_BREADY, o_ARVALID, o_RREADY;
  logic [15:0]   o_WDATA;

  axi_fft_master #(.DATA_WIDTH(DW), .ID_W_WIDTH(2), .ID_R_WIDTH(2), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_START(start), .i_BASE_ADDR(base_addr), .i_LEN(len_in),
    .i_W_ID(w_id), .i_R_ID(r_id), .i_S_DATA(s_data), .i_S_VALID(s_valid), .o_S_READY(o_S_READY),
    .o_M_DATA(o_M_DATA), .o_M_VALID(o_M_VALID), .i_M_READY(m_ready), .i_CALC_END(calc_end),
    .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ERROR(o_ERROR), .o_DBG_STATE(o_DBG_STATE),
    .o_AWADDR(o_AWADDR), .o_AWLEN(o_AWLEN), .o_AWSIZE(o_AWSIZE), .o_AWBURST(o_AWBURST),
    .o_AWID(o_AWID), .o_AWVALID(o_AWVALID), .i_AWREADY(awready),
    .o_WDATA(o_WDATA), .o_WSTRB(o_WSTRB), .o_WVALID(o_WVALID), .o_WLAST(o_WLAST), .i_WREADY(wready),
    .i_BVALID(bvalid), .i_BID(bid_in), .o_BREADY(o_BREADY),
    .o_ARADDR(o_ARADDR), .o_ARLEN(o_ARLEN), .o_ARSIZE(o_ARSIZE), .o_ARBURST(o_ARBURST),
    .o_ARID(o_ARID), .o_ARVALID(o_ARVALID), .i_ARREADY(arready),
    .i_RDATA(rdata), .i_RID(rid_in), .i_RVALID(rvalid), .i_RLAST(rlast), .o_RREADY(o_RREADY)
  );

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [16:0]   exp_w_q[$];
  logic [DW-1:0] exp_m_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] smp(input int k);
    return 16'(32'h1111 * (k + 1));
  endfunction

  function automatic logic [DW-1:0] rdv(input int k);
    return DW'(32'hA5A5_0000 + 32'(k));
  endfunction

  // Monitor: every W beat and result beat the DUT hands over is matched against the queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_DONE) done_cnt++;
      if (o_WVALID && wready) begin
        if (exp_w_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL w_unexpected: got beat 0x%0h expected none", o_WDATA);
        end else check("w_beat", 64'({o_WLAST, o_WDATA}), 64'(exp_w_q.pop_front()));
      end
      if (o_M_VALID && m_ready) begin
        if (exp_m_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL m_unexpected: got beat 0x%0h expected none", o_M_DATA);
        end else check("m_beat", 64'(o_M_DATA), 64'(exp_m_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_cmd(input logic [11:0] b, input logic [7:0] l, input logic [1:0] wi, input logic [1:0] ri);
    base_addr = b; len_in = l; w_id = wi; r_id = ri; start = 1'b1;
    tick();
    start = 1'b0;
    check("awvalid_after_start", 64'(o_AWVALID), 64'd1);
    check("aw_fields", 64'({o_AWADDR, o_AWLEN, o_AWSIZE, o_AWBURST, o_AWID}),
          64'({b & 12'hFFE, l, 3'b001, 2'b01, wi}));
    check("err_cleared_on_start", 64'(o_ERROR), 64'd0);
  endtask

  task automatic aw_phase(input int stall);
    for (int i = 0; i < stall; i++) begin
      awready = 1'b0; s_valid = 1'b1; s_data = smp(0); wready = 1'b1;
      @(negedge clk);
      check("aw_hold_no_w", 64'({o_AWVALID, o_WVALID, o_S_READY}), 64'(3'b100));
      tick();
    end
    awready = 1'b1;
    @(negedge clk);
    check("awvalid", 64'(o_AWVALID), 64'd1);
    tick();
    awready = 1'b0; s_valid = 1'b0; wready = 1'b0;
    check("state_w", 64'(o_DBG_STATE), 64'd2);
  endtask

  task automatic w_phase(input int l, input int stop, input bit tog);
    int k; int cyc; bit hs;
    k = 0; cyc = 0;
    for (int i = 0; i <= l; i++) exp_w_q.push_back({(i == l), smp(i)});
    while (k < stop && cyc < 300) begin
      s_valid = 1'b1; s_data = smp(k); wready = tog ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      check("s_ready_mirror", 64'(o_S_READY), 64'(wready));
      hs = o_WVALID && wready;
      tick();
      if (hs) k++;
      cyc++;
    end
    s_valid = 1'b0; wready = 1'b0;
    if (cyc >= 300) check("w_budget", 64'(k), 64'(stop));
  endtask

  task automatic b_phase(input logic [1:0] bi, input bit exp_err);
    bvalid = 1'b1; bid_in = bi;
    @(negedge clk);
    check("b_state_bready", 64'({o_DBG_STATE, o_BREADY}), 64'({3'd3, 1'b1}));
    tick();
    bvalid = 1'b0;
    check("b_error", 64'(o_ERROR), 64'(exp_err));
    check("state_wait_calc", 64'(o_DBG_STATE), 64'd4);
  endtask

  task automatic calc_ar(input int dly, input logic [11:0] b, input logic [7:0] l, input logic [1:0] ri);
    for (int i = 0; i < dly; i++) begin
      calc_end = 1'b0;
      @(negedge clk);
      check("arvalid_low_while_calc", 64'(o_ARVALID), 64'd0);
      tick();
    end
    calc_end = 1'b1;
    tick();
    calc_end = 1'b0;
    check("arvalid_after_calc", 64'(o_ARVALID), 64'd1);
    check("ar_fields", 64'({o_ARADDR, o_ARLEN, o_ARSIZE, o_ARBURST, o_ARID}),
          64'({b & 12'hFFE, l, 3'd2, 2'b01, ri}));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("state_r", 64'(o_DBG_STATE), 64'd6);
  endtask

  task automatic r_phase(input int last_at, input logic [1:0] rr, input bit stall, input bit exp_err);
    int k; int cyc; int d0; bit hs; bit fin;
    k = 0; cyc = 0; fin = 1'b0; d0 = done_cnt;
    for (int i = 0; i <= last_at; i++) exp_m_q.push_back(rdv(i));
    while (!fin && cyc < 300) begin
      rvalid = 1'b1; rdata = rdv(k); rid_in = rr; rlast = (k == last_at);
      m_ready = stall ? !(cyc >= 2 && cyc < 5) : 1'b1;
      @(negedge clk);
      check("rready_mirror", 64'(o_RREADY), 64'(m_ready));
      hs = rvalid && o_RREADY;
      tick();
      if (hs) begin
        if (k == last_at) fin = 1'b1;
        k++;
      end
      cyc++;
    end
    rvalid = 1'b0; rlast = 1'b0; m_ready = 1'b0;
    if (!fin) check("r_budget", 64'(k), 64'(last_at + 1));
    check("done_after_rlast", 64'({o_DONE, o_BUSY}), 64'(2'b11));
    check("r_error", 64'(o_ERROR), 64'(exp_err));
    tick();
    check("done_pulse_once", 64'(done_cnt), 64'(d0 + 1));
    check("idle_after_done", 64'({o_BUSY, o_DONE}), 64'd0);
  endtask

  task automatic txn(input logic [11:0] b, input logic [7:0] l, input logic [1:0] wi, input logic [1:0] ri,
                     input int aw_stall, input bit wtog, input logic [1:0] bi, input bit ign, input int cdel,
                     input logic [1:0] rr, input int last_at, input bit rstall, input bit exp_err);
    start_cmd(b, l, wi, ri);
    aw_phase(aw_stall);
    w_phase(int'(l), int'(l) + 1, wtog);
    b_phase(bi, bi != wi);
    if (ign) begin
      base_addr = 12'h7FE; len_in = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      check("start_ignored_busy", 64'(o_DBG_STATE), 64'd4);
    end
    calc_ar(cdel, b, l, ri);
    r_phase(last_at, rr, rstall, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got %0d tests run", n_tests);
    $fatal(1, "global timeout");
  end

  initial begin
    start = 0; s_valid = 0; m_ready = 0; calc_end = 0; base_addr = 0; len_in = 0;
    w_id = 0; r_id = 0; bid_in = 0; rid_in = 0; awready = 0; wready = 0; bvalid = 0;
    arready = 0; rvalid = 0; rlast = 0;
    s_data = 16'hBEEF; rdata = 32'hDEAD_BEEF;
    repeat (3) tick();
    check("reset_ctrl", 64'({o_AWVALID, o_WVALID, o_WLAST, o_BREADY, o_ARVALID, o_RREADY,
                             o_S_READY, o_M_VALID, o_BUSY, o_DONE, o_ERROR}), 64'd0);
    rstn = 1'b1;
    tick();
    check("reset_aw_fields", 64'({o_AWADDR, o_AWLEN, o_AWSIZE, o_AWBURST, o_AWID, o_WSTRB}), 64'd0);
    check("reset_ar_fields", 64'({o_ARADDR, o_ARLEN, o_ARSIZE, o_ARBURST, o_ARID}), 64'd0);
    check("reset_data", 64'({o_WDATA, o_M_DATA}), 64'd0);
    check("reset_state", 64'({o_DBG_STATE, o_BUSY}), 64'd0);
    s_data = 16'h0; rdata = '0;

    // Plain len=3 command, AW stalled, long calc wait.
    txn(12'h000, 8'd3, 2'd1, 2'd2, 2, 1'b0, 2'd1, 1'b0, 20, 2'd2, 3, 1'b0, 1'b0);
    // len=7, odd base, WREADY toggling, result stall, stray START in WAIT_CALC.
    txn(12'h123, 8'd7, 2'd3, 2'd1, 0, 1'b1, 2'd3, 1'b1, 0, 2'd1, 7, 1'b1, 1'b0);
    // BID mismatch (2 vs 1) makes the error sticky through the read.
    txn(12'h200, 8'd1, 2'd1, 2'd0, 0, 1'b0, 2'd2, 1'b0, 3, 2'd0, 1, 1'b0, 1'b1);
    // Next START clears it; RLAST on beat 2 of len=3 ends early with error.
    txn(12'h010, 8'd3, 2'd0, 2'd0, 1, 1'b0, 2'd0, 1'b0, 0, 2'd0, 1, 1'b0, 1'b1);
    // len=1 read burst without RLAST on beat 2: error, stays in R until RLAST on beat 3.
    txn(12'h020, 8'd1, 2'd2, 2'd3, 0, 1'b0, 2'd2, 1'b0, 0, 2'd3, 2, 1'b0, 1'b1);
    // Single beat, RID mismatch.
    txn(12'h030, 8'd0, 2'd1, 2'd2, 0, 1'b0, 2'd1, 1'b0, 0, 2'd3, 0, 1'b0, 1'b1);

    // Reset while beat 3 of 8 is offered.
    start_cmd(12'h100, 8'd7, 2'd1, 2'd1);
    aw_phase(0);
    w_phase(7, 2, 1'b0);
    s_valid = 1'b1; s_data = smp(2); wready = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("midw_reset_valids", 64'({o_AWVALID, o_WVALID, o_ARVALID, o_M_VALID, o_S_READY, o_BUSY}), 64'd0);
    exp_w_q.delete();
    s_valid = 1'b0; wready = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    txn(12'h040, 8'd7, 2'd2, 2'd3, 0, 1'b0, 2'd2, 1'b0, 0, 2'd3, 7, 1'b0, 1'b0);

    // AWREADY stuck low.
    begin
      int d0;
      d0 = done_cnt;
      start_cmd(12'h050, 8'd2, 2'd0, 2'd0);
      awready = 1'b0;
      repeat (40) tick();
`ifdef AXI_MASTER_TIMEOUT_EN
      check("timeout_idle", 64'({o_BUSY, o_AWVALID}), 64'd0);
      check("timeout_error", 64'(o_ERROR), 64'd1);
`else
      check("stuck_in_aw", 64'({o_DBG_STATE, o_AWVALID, o_BUSY}), 64'({3'd1, 1'b1, 1'b1}));
      check("stuck_no_error", 64'(o_ERROR), 64'd0);
`endif
      check("stuck_no_done", 64'(done_cnt), 64'(d0));
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    check("queues_drained", 64'(exp_w_q.size() + exp_m_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
